fetch_unit: RTL

Parametrised instruction-fetch stage for the 5-stage RISC-V pipeline, replacing the fixed single-cycle-memory fetch. It owns the PC, issues requests to a variable-latency instruction memory over a request/response handshake, and buffers returned instructions in a DEPTH-entry queue. It drives the IF/ID register with stall, flush and branch-redirect support from the hazard unit and Execute stage.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency instruction memory,
// buffers responses in a small queue and drives the IF/ID register.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthLim = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pcf_q;
    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [31:0]     q_instr_q [DEPTH];
    logic [PW-1:0]   q_head_q, q_tail_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] fl_pc_q   [DEPTH];
    logic [PW-1:0]   fl_head_q, fl_tail_q;
    logic [CW-1:0]   outst_q, discard_q;

    logic accept, resp, drop, push, pop;

    always_comb begin
        imem_req  = !reset && !PCSrcE && (({1'b0, count_q} + {1'b0, outst_q}) < DepthLim);
        imem_addr = pcf_q;
        accept    = imem_req && imem_ready;
        resp      = !reset && imem_rvalid && (outst_q != '0);
        drop      = resp && ((discard_q != '0) || PCSrcE);
        push      = resp && !drop;
        pop       = !reset && !PCSrcE && !FlushD && !StallD && (count_q != '0);
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counters below.
    always_ff @(posedge clk) begin
        if (accept) begin
            fl_pc_q[fl_tail_q] <= pcf_q;
        end
        if (push) begin
            q_pc_q[q_tail_q]    <= fl_pc_q[fl_head_q];
            q_instr_q[q_tail_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q     <= RESET_PC;
            q_head_q  <= '0;
            q_tail_q  <= '0;
            count_q   <= '0;
            fl_head_q <= '0;
            fl_tail_q <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            InstrD    <= NOP;
            PCD       <= '0;
            PCPlus4D  <= '0;
            ValidD    <= 1'b0;
        end else begin
            outst_q <= outst_q + CW'(accept) - CW'(resp);
            if (PCSrcE) begin
                pcf_q     <= PCTargetE;
                q_head_q  <= '0;
                q_tail_q  <= '0;
                count_q   <= '0;
                fl_head_q <= '0;
                fl_tail_q <= '0;
                // Everything still in flight after this cycle belongs to the wrong path.
                discard_q <= outst_q - CW'(resp);
            end else begin
                if (accept) begin
                    pcf_q     <= pcf_q + XLEN'(4);
                    fl_tail_q <= fl_tail_q + PW'(1);
                end
                if (resp) begin
                    if (discard_q != '0) begin
                        discard_q <= discard_q - CW'(1);
                    end else begin
                        fl_head_q <= fl_head_q + PW'(1);
                    end
                end
                if (push) begin
                    q_tail_q <= q_tail_q + PW'(1);
                end
                if (pop) begin
                    q_head_q <= q_head_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end

            if (PCSrcE || FlushD) begin
                InstrD   <= NOP;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else if (!StallD) begin
                if (count_q != '0) begin
                    InstrD   <= q_instr_q[q_head_q];
                    PCD      <= q_pc_q[q_head_q];
                    PCPlus4D <= q_pc_q[q_head_q] + XLEN'(4);
                    ValidD   <= 1'b1;
                end else begin
                    InstrD   <= NOP;
                    PCD      <= '0;
                    PCPlus4D <= '0;
                    ValidD   <= 1'b0;
                end
            end
        end
    end

endmodule
